// File: rtl/count_pwm_pkg.sv
// Shared types and helpers for the count-driven PWM generator.
package count_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DRAIN
    } state_t;

    localparam int CNT_W_DEF = 4;
    localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Duty values above a full period saturate to always-high.
    function automatic int clamp_duty(input int d, input int w);
        int lim;
        lim = 1 << w;
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/count_wrap_detect.sv
// Samples the upstream count, detects MAX->0 wraps and illegal steps.
// Sequence checking is built only with COUNT_PWM_SEQ_CHECK_EN defined.
module count_wrap_detect
    import count_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             wrap,
    output logic             seq_err
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            cnt_vld <= 1'b0;
        end else begin
            cnt_q   <= cnt_i;
            cnt_vld <= 1'b1;
        end
    end

    assign wrap = cnt_vld && (cnt_q == MAX) && (cnt_i == '0);

`ifdef COUNT_PWM_SEQ_CHECK_EN
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;
    // A jump to zero is an upstream reset, not an error.
    assign seq_err = cnt_vld && (cnt_i != cnt_inc) && (cnt_i != '0);
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external wrap-around count.
// Optional sequence checker: define COUNT_PWM_SEQ_CHECK_EN.
module count_pwm_gen
    import count_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W:0]   duty_i,
    input  logic             duty_wr,
    input  logic             err_clr,
    output logic             pwm_o,
    output logic             wrap_o,
    output logic [PER_W-1:0] period_cnt_o,
    output logic             running_o,
    output logic             seq_err_o
);

    state_t         state;
    state_t         state_n;
    logic           wrap;
    logic           seq_evt;
    logic           pwm_n;
    logic           per_inc;
    logic           below;
    logic [CNT_W:0] duty_shadow;
    logic [CNT_W:0] duty_active;
    logic [CNT_W:0] duty_clamped;
    logic [CNT_W:0] duty_eff;

    count_wrap_detect #(
        .CNT_W(CNT_W)
    ) u_detect (
        .clk    (clk),
        .reset  (reset),
        .cnt_i  (cnt_i),
        .wrap   (wrap),
        .seq_err(seq_evt)
    );

    assign duty_clamped = (CNT_W+1)'(clamp_duty(int'(duty_i), CNT_W));

    // At a wrap the new period uses the duty being loaded this edge.
    assign duty_eff = !wrap   ? duty_active :
                      duty_wr ? duty_clamped : duty_shadow;

    assign below     = {1'b0, cnt_i} < duty_eff;
    assign running_o = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        pwm_n   = 1'b0;
        per_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_n = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (wrap) begin
                    state_n = RUN;
                    pwm_n   = below;
                end
            end
            RUN: begin
                pwm_n   = below;
                per_inc = wrap;
                if (!enable) state_n = DRAIN;
            end
            DRAIN: begin
                pwm_n   = below;
                per_inc = wrap;
                if (enable) begin
                    state_n = RUN;
                end else if (wrap) begin
                    state_n = IDLE;
                    pwm_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_o        <= 1'b0;
            wrap_o       <= 1'b0;
            period_cnt_o <= '0;
            duty_shadow  <= '0;
            duty_active  <= '0;
        end else begin
            pwm_o  <= pwm_n;
            wrap_o <= wrap;
            if (per_inc) period_cnt_o <= period_cnt_o + 1'b1;
            if (duty_wr) duty_shadow  <= duty_clamped;
            if (wrap)    duty_active  <= duty_eff;
        end
    end

`ifdef COUNT_PWM_SEQ_CHECK_EN
    // A fresh error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)        seq_err_o <= 1'b0;
        else if (seq_evt) seq_err_o <= 1'b1;
        else if (err_clr) seq_err_o <= 1'b0;
    end
`else
    logic unused_chk;

    assign unused_chk = err_clr ^ seq_evt;
    assign seq_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// Self-checking bench for count_pwm_gen.
module tb_count_pwm_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       duty_wr = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic [4:0] duty_i = 5'd0;
    logic       pwm;
    logic       wrap;
    logic       running;
    logic       serr;
    logic [7:0] per;

    always #5 clk = ~clk;

    count_pwm_gen #(
        .CNT_W(4),
        .PER_W(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cnt_i       (cnt),
        .duty_i      (duty_i),
        .duty_wr     (duty_wr),
        .err_clr     (err_clr),
        .pwm_o       (pwm),
        .wrap_o      (wrap),
        .period_cnt_o(per),
        .running_o   (running),
        .seq_err_o   (serr)
    );

`ifdef COUNT_PWM_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    typedef struct packed {
        logic       pwm;
        logic       wrap;
        logic [7:0] per;
        logic       run;
        logic       serr;
    } exp_t;

    typedef struct packed {
        logic       dw;
        logic [4:0] di;
        logic [4:0] hi;
    } vec_t;

    exp_t  sb[$];
    int    checks = 0;
    int    failures = 0;
    string tag = "init";

    function automatic exp_t mk(input logic p, input logic w,
                                input logic [7:0] pc,
                                input logic r, input logic s);
        exp_t e;
        e.pwm  = p;
        e.wrap = w;
        e.per  = pc;
        e.run  = r;
        e.serr = s;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s %s: got %0d want %0d t=%0t",
                     tag, name, act, req, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] c,
                       input logic en, input logic dw,
                       input logic [4:0] di, input logic clr,
                       input exp_t e);
        exp_t x;
        @(negedge clk);
        reset   = rst;
        cnt     = c;
        enable  = en;
        duty_wr = dw;
        duty_i  = di;
        err_clr = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        cmp("pwm_o", {7'd0, pwm}, {7'd0, x.pwm});
        cmp("wrap_o", {7'd0, wrap}, {7'd0, x.wrap});
        cmp("period_cnt_o", per, x.per);
        cmp("running_o", {7'd0, running}, {7'd0, x.run});
        cmp("seq_err_o", {7'd0, serr}, {7'd0, x.serr});
    endtask

    task automatic do_reset;
        cyc(1'b1, 4'd15, 1'b0, 1'b0, 5'd0, 1'b0, mk(0, 0, 0, 0, 0));
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0, mk(0, 0, 0, 0, 0));
    endtask

    vec_t        vt[7];
    logic [3:0]  c;
    logic [3:0]  sc[12];
    logic [11:0] clr_m;
    logic [11:0] err_m;
    logic [4:0]  d;
    logic [4:0]  hp;
    logic        p;
    logic        en;
    logic        act;
    logic        dw;
    int          pc;

    initial begin
        vt[0] = '{dw: 1'b1, di: 5'd0,  hi: 5'd0};
        vt[1] = '{dw: 1'b1, di: 5'd5,  hi: 5'd5};
        vt[2] = '{dw: 1'b1, di: 5'd16, hi: 5'd16};
        vt[3] = '{dw: 1'b1, di: 5'd20, hi: 5'd16};
        vt[4] = '{dw: 1'b0, di: 5'd9,  hi: 5'd0};
        vt[5] = '{dw: 1'b1, di: 5'd15, hi: 5'd15};
        vt[6] = '{dw: 1'b1, di: 5'd31, hi: 5'd16};

        tag = "reset";
        do_reset;

        // Count starts at 10, so the first wrap is at step 6.
        for (int r = 0; r < 7; r++) begin
            tag = $sformatf("duty_row%0d", r);
            do_reset;
            for (int i = 0; i < 54; i++) begin
                c  = 4'((10 + i) % 16);
                p  = (i >= 6) && ({1'b0, c} < vt[r].hi);
                pc = (i < 6) ? 0 : (i - 6) / 16;
                cyc(1'b0, c, 1'b1, (i == 0) && vt[r].dw, vt[r].di, 1'b0,
                    mk(p, (i >= 6) && (c == 0), 8'(pc), i >= 6, 1'b0));
            end
        end

        tag = "mid_update";
        do_reset;
        for (int i = 0; i < 56; i++) begin
            c  = 4'((12 + i) % 16);
            dw = (i == 0) || (i == 11) || (i == 36);
            d  = (i == 0) ? 5'd3 : (i == 11) ? 5'd12 : 5'd7;
            pc = (i < 4) ? 0 : (i - 4) / 16;
            hp = (pc == 0) ? 5'd3 : (pc == 1) ? 5'd12 : 5'd7;
            p  = (i >= 4) && ({1'b0, c} < hp);
            cyc(1'b0, c, 1'b1, dw, d, 1'b0,
                mk(p, (i >= 4) && (c == 0), 8'(pc), i >= 4, 1'b0));
        end

        tag = "disable";
        do_reset;
        for (int i = 0; i < 72; i++) begin
            c   = 4'((12 + i) % 16);
            en  = !((i >= 24 && i < 46) || (i >= 56 && i < 60));
            act = (i >= 4 && i < 36) || (i >= 52);
            p   = act && (c < 4'd5);
            pc  = (i < 20) ? 0 : (i < 36) ? 1 : (i < 68) ? 2 : 3;
            cyc(1'b0, c, en, i == 0, 5'd5, 1'b0,
                mk(p, (i >= 4) && (c == 0), 8'(pc), act, 1'b0));
        end

        tag = "seq_check";
        do_reset;
        sc    = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10,
                  4'd11, 4'd0, 4'd1, 4'd5, 4'd6, 4'd7};
        clr_m = 12'b0111_0000_0000;
        err_m = 12'b0010_1111_0000;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, sc[i], 1'b0, 1'b0, 5'd0, clr_m[i],
                mk(0, 0, 0, 0, err_m[i] & SEQ_ON));
        end

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_pwm_gen.md
Name: count_pwm_gen

Overview:
- Consumer stage for the free-running 4-bit wrap-around counter (which updates on the falling clock edge).
- Samples the count on the rising edge and produces a PWM waveform whose duty is programmable, with updates applied glitch-free at period boundaries.
- Also flags period wraps, counts completed periods, and optionally checks that the count sequence is legal.

Parameters:
- CNT_W, 4: width of the incoming count; period = 2**CNT_W cycles.
- PER_W, 8: width of the completed-period counter.

Ports:
- clk  in  1  clock; all flops on rising edge.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  request PWM generation.
- cnt_i  in  CNT_W  unsigned count from upstream counter.
- duty_i  in  CNT_W+1  high-time in cycles per period, 0..2**CNT_W.
- duty_wr  in  1  one-cycle strobe that loads duty_i into the shadow register.
- err_clr  in  1  clears seq_err_o.
- pwm_o  out  1  PWM output, registered.
- wrap_o  out  1  one-cycle pulse on a MAX->0 count transition.
- period_cnt_o  out  PER_W  completed periods while in RUN; wraps modulo 2**PER_W.
- running_o  out  1  high in RUN or DRAIN.
- seq_err_o  out  1  sticky count-sequence error.

Behaviour:
- Reset (synchronous, active-high):
  - pwm_o=0, wrap_o=0, period_cnt_o=0, running_o=0, seq_err_o=0.
  - duty_shadow=0, duty_active=0, cnt_q=0, cnt_vld=0, state=IDLE.
- Count sampling: cnt_q <= cnt_i every cycle; cnt_vld <= 1 one cycle after reset release.
- Wrap detect: wrap = cnt_vld && cnt_q==MAX && cnt_i==0, where MAX=2**CNT_W-1. wrap_o is wrap registered (1-cycle latency).
- Duty values:
  - duty_wr: duty_shadow <= min(duty_i, 2**CNT_W); values above 2**CNT_W clamp.
  - duty_active <= duty_shadow only at wrap, or on ARMED->RUN.
  - duty_wr in the same cycle as wrap: the new duty_i (clamped) bypasses the shadow and takes effect at this wrap.
- FSM, states IDLE, ARMED, RUN, DRAIN:
  - IDLE: pwm_o=0. enable=1 -> ARMED.
  - ARMED: pwm_o=0. enable=0 -> IDLE. wrap -> RUN, loading duty_active.
  - RUN: pwm_o <= (cnt_i < duty_active).
    - Each wrap increments period_cnt_o.
    - enable=0 -> DRAIN.
  - DRAIN: PWM continues unchanged.
    - enable=1 -> RUN.
    - wrap -> IDLE; period_cnt_o still increments; pwm_o=0 from the next cycle.
- PWM generation:
  - Latency: pwm_o reflects cnt_i sampled one rising edge earlier.
  - duty 0 -> constant low; duty 2**CNT_W -> constant high; otherwise high for exactly duty_active cycles per period, starting at count 0.
  - Periods always start at count 0, so a partial first period is never emitted.
- Sequence check:
  - Error when cnt_vld && cnt_i != cnt_q+1 (mod 2**CNT_W) && cnt_i != 0. A jump to 0 is legal because it is an upstream reset.
  - seq_err_o is set the cycle after the error and held.
  - err_clr clears it; if err_clr and a new error coincide, the error wins.
  - seq_err_o does not affect the FSM.
- Mid-operation reset: returns to IDLE immediately with the reset values above; the shadow duty is lost.
- Upstream counter held at 0 (its reset): no wraps occur, so the FSM stays in ARMED or DRAIN and RUN emits the count-0 level.

Optional Feature:
- COUNT_PWM_SEQ_CHECK_EN defined: sequence checker built as described.
- Not defined: checker logic removed, seq_err_o tied 0, err_clr ignored.

Decomposition:
- Shared package count_pwm_pkg holds:
  - state enum (IDLE, ARMED, RUN, DRAIN);
  - localparam CNT_MAX function of CNT_W;
  - duty clamp function.
- One sub-module, count_wrap_detect: holds cnt_q/cnt_vld and produces wrap and seq_err. It is instantiated once.

Test Plan:
- Reset: hold reset 2 cycles with a running count -> all outputs 0, state IDLE, and no wrap_o during reset.
- Basic PWM: duty_wr with duty_i=5, enable=1, count 0..15 repeating:
  - pwm_o stays 0 until the first wrap;
  - then it is high for 5 cycles and low for 11 per period;
  - wrap_o pulses every 16 cycles;
  - period_cnt_o increments 1,2,3.
- Boundaries: duty 0 -> pwm_o constant 0; duty 16 -> constant 1; duty 20 -> clamped, constant 1.
- Mid-period update: duty_wr 12 at count 7 of a duty-3 period -> the current period keeps 3 high cycles and the next period has 12. Also drive duty_wr on the wrap cycle -> the new value is applied to the following period.
- Disable: enable drops at count 4 -> running_o stays 1 until the wrap; then IDLE, pwm_o 0, period_cnt_o frozen. Re-assert enable during DRAIN -> back to RUN with no gap.
- Sequence check (macro on): inject count jump 6->9 -> seq_err_o=1 next cycle and held; jump 11->0 -> no error. Pulse err_clr -> 0. With the macro off, the same stimulus leaves seq_err_o=0.
